// File: rtl/junction_sequencer.sv
// Two-road junction phase sequencer with pedestrian crossing.
// Drives NS and EW lamp heads through green, yellow and all-red phases.
module junction_sequencer #(
    parameter int unsigned GREEN_CYC  = 8,
    parameter int unsigned YELLOW_CYC = 3,
    parameter int unsigned ALLRED_CYC = 2,
    parameter int unsigned PED_CYC    = 5
) (
    input  logic clk,
    input  logic rst_an,
    input  logic ew_car,
    input  logic ped_req,
    output logic ped_ack,
    output logic ped_walk,
    output logic ns_red,
    output logic ns_yellow,
    output logic ns_green,
    output logic ew_red,
    output logic ew_yellow,
    output logic ew_green
);

    typedef enum logic [2:0] {
        RED_NS = 3'd0,
        NS_G   = 3'd1,
        NS_Y   = 3'd2,
        RED_EW = 3'd3,
        EW_G   = 3'd4,
        EW_Y   = 3'd5,
        WALK   = 3'd6
    } state_t;

    localparam logic [7:0] T_GREEN  = 8'(GREEN_CYC - 1);
    localparam logic [7:0] T_YELLOW = 8'(YELLOW_CYC - 1);
    localparam logic [7:0] T_ALLRED = 8'(ALLRED_CYC - 1);
    localparam logic [7:0] T_PED    = 8'(PED_CYC - 1);

    state_t     state;
    state_t     state_nx;
    logic [7:0] timer;
    logic [7:0] timer_nx;
    logic       ped_pending;
    logic       pending_nx;
    logic       ack_nx;
    logic       tdone;
    logic       enter_walk;
    logic       req_set;

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state       <= RED_NS;
            timer       <= T_ALLRED;
            ped_pending <= 1'b0;
            ped_ack     <= 1'b0;
        end else begin
            state       <= state_nx;
            timer       <= timer_nx;
            ped_pending <= pending_nx;
            ped_ack     <= ack_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tdone    = (timer == 8'd0);
        case (state)
            RED_NS: if (tdone) state_nx = NS_G;
            NS_G:   if (tdone && (ew_car || ped_pending)) state_nx = NS_Y;
            NS_Y:   if (tdone) state_nx = RED_EW;
            RED_EW: if (tdone) state_nx = ped_pending ? WALK : EW_G;
            WALK:   if (tdone) state_nx = ew_car ? EW_G : RED_NS;
            EW_G:   if (tdone) state_nx = EW_Y;
            EW_Y:   if (tdone) state_nx = RED_NS;
            default: state_nx = RED_NS;
        endcase
    end

    // Reload on every state entry; otherwise count down and rest at zero.
    always_comb begin
        timer_nx = tdone ? 8'd0 : timer - 8'd1;
        if (state_nx != state) begin
            case (state_nx)
                NS_G, EW_G:   timer_nx = T_GREEN;
                NS_Y, EW_Y:   timer_nx = T_YELLOW;
                WALK:         timer_nx = T_PED;
                default:      timer_nx = T_ALLRED;
            endcase
        end
    end

    // Requests during walk entry or walk itself are served by that walk.
    always_comb begin
        enter_walk = (state_nx == WALK) && (state != WALK);
        req_set    = ped_req && !ped_pending && (state != WALK) && !enter_walk;
        ack_nx     = req_set;
        pending_nx = enter_walk ? 1'b0 : (ped_pending || req_set);
    end

    always_comb begin
        ns_red    = 1'b1;
        ns_yellow = 1'b0;
        ns_green  = 1'b0;
        ew_red    = 1'b1;
        ew_yellow = 1'b0;
        ew_green  = 1'b0;
        ped_walk  = 1'b0;
        case (state)
            NS_G: begin
                ns_red   = 1'b0;
                ns_green = 1'b1;
            end
            NS_Y: begin
                ns_red    = 1'b0;
                ns_yellow = 1'b1;
            end
            EW_G: begin
                ew_red   = 1'b0;
                ew_green = 1'b1;
            end
            EW_Y: begin
                ew_red    = 1'b0;
                ew_yellow = 1'b1;
            end
            WALK:    ped_walk = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_junction_sequencer.sv
// Bench for junction_sequencer: phase-list model plus directed checks.
module tb_junction_sequencer;

    localparam int G = 8;
    localparam int Y = 3;
    localparam int A = 2;
    localparam int P = 5;

    localparam int PH_RNS  = 0;
    localparam int PH_NSG  = 1;
    localparam int PH_NSY  = 2;
    localparam int PH_REW  = 3;
    localparam int PH_EWG  = 4;
    localparam int PH_EWY  = 5;
    localparam int PH_WALK = 6;

    logic clk = 1'b0;
    logic rst_an = 1'b0;
    logic ew_car = 1'b0;
    logic ped_req = 1'b0;
    logic ped_ack, ped_walk;
    logic ns_red, ns_yellow, ns_green;
    logic ew_red, ew_yellow, ew_green;

    int tests = 0;
    int fails = 0;

    junction_sequencer #(
        .GREEN_CYC(G), .YELLOW_CYC(Y), .ALLRED_CYC(A), .PED_CYC(P)
    ) dut (
        .clk(clk), .rst_an(rst_an), .ew_car(ew_car), .ped_req(ped_req),
        .ped_ack(ped_ack), .ped_walk(ped_walk),
        .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
        .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green)
    );

    always #5 clk = ~clk;

    // Model: current phase and how many cycles it has been occupied.
    int m_ph = PH_RNS;
    int m_cnt = 0;
    bit m_pend = 0;
    bit m_ack = 0;
    int nph;
    bit mset;

    function automatic int plen(int ph);
        case (ph)
            PH_NSG, PH_EWG: return G;
            PH_NSY, PH_EWY: return Y;
            PH_WALK:        return P;
            default:        return A;
        endcase
    endfunction

    always @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            m_ph = PH_RNS; m_cnt = 0; m_pend = 0; m_ack = 0;
        end else begin
            nph = m_ph;
            if (m_cnt + 1 >= plen(m_ph)) begin
                case (m_ph)
                    PH_RNS:  nph = PH_NSG;
                    PH_NSG:  if (ew_car || m_pend) nph = PH_NSY;
                    PH_NSY:  nph = PH_REW;
                    PH_REW:  nph = m_pend ? PH_WALK : PH_EWG;
                    PH_WALK: nph = ew_car ? PH_EWG : PH_RNS;
                    PH_EWG:  nph = PH_EWY;
                    default: nph = PH_RNS;
                endcase
            end
            mset = ped_req && !m_pend && m_ph != PH_WALK && nph != PH_WALK;
            m_ack = mset;
            if (nph == PH_WALK && m_ph != PH_WALK) m_pend = 0;
            else if (mset) m_pend = 1;
            m_cnt = (nph != m_ph) ? 0 : m_cnt + 1;
            m_ph = nph;
        end
    end

    logic [7:0] got, want;
    always @(negedge clk) begin
        got  = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
                ped_walk, ped_ack};
        want = {!(m_ph == PH_NSG || m_ph == PH_NSY), m_ph == PH_NSY,
                m_ph == PH_NSG, !(m_ph == PH_EWG || m_ph == PH_EWY),
                m_ph == PH_EWY, m_ph == PH_EWG, m_ph == PH_WALK, m_ack};
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL model t=%0t got %b want %b", $time, got, want);
        end
        tests++;
        if (!($onehot({ns_red, ns_yellow, ns_green}) &&
              $onehot({ew_red, ew_yellow, ew_green}))) begin
            fails++;
            $display("FAIL onehot t=%0t got %b", $time, got[7:2]);
        end
    end

    int acks = 0;
    always @(negedge clk) if (ped_ack) acks++;

    task automatic chk(string nm, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    int e;
    int bad;
    int a0;
    int rises[$];
    int ng, ny, eg;
    bit prev_g;
    bit found;

    initial begin
        #3;
        chk("rst_lamps", {ns_red, ns_yellow, ns_green, ew_red, ew_yellow,
                          ew_green, ped_walk, ped_ack}, 8'b100_100_00);
        #9 rst_an = 1'b1;
        step();
        chk("cyc0_red", {ns_red, ew_red, ns_green}, 3'b110);
        step();
        chk("cyc2_green", {ns_green, ew_red}, 2'b11);

        bad = 0;
        a0 = acks;
        for (int i = 0; i < 100; i++) begin
            step();
            if (!ns_green || ped_walk || ped_ack) bad++;
        end
        chk("idle_hold", bad, 0);
        chk("idle_no_ack", acks - a0, 0);

        ew_car = 1'b1;
        step();
        chk("late_demand_ny", ns_yellow, 1);
        e = 0; ng = 0; ny = 0; eg = 0; prev_g = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            e++;
            if (ns_green && !prev_g) rises.push_back(e);
            prev_g = ns_green;
            if (rises.size() == 1) begin
                ng += int'(ns_green);
                ny += int'(ns_yellow);
                eg += int'(ew_green);
            end
        end
        chk("rises", rises.size(), 2);
        if (rises.size() >= 2) chk("period", rises[1] - rises[0], 26);
        chk("ns_g_len", ng, G);
        chk("ns_y_len", ny, Y);
        chk("ew_g_len", eg, G);

        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (ns_green && !prev_g) found = 1;
            prev_g = ns_green;
        end
        chk("wait_ns_g", found, 1);
        ew_car = 1'b0;
        a0 = acks;
        repeat (3) step();
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        chk("ack_cyc4", ped_ack, 1);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        chk("no_second_ack", ped_ack, 0);
        repeat (2) step();
        chk("ns_g_min", ns_green, 1);
        step();
        chk("ns_y_enter", ns_yellow, 1);
        repeat (3) step();
        chk("red_ew", {ns_red, ew_red, ped_walk}, 3'b110);
        step();
        ped_req = 1'b1;
        step();
        chk("walk_enter", ped_walk, 1);
        repeat (4) step();
        chk("walk_len", ped_walk, 1);
        step();
        ped_req = 1'b0;
        chk("walk_exit", {ped_walk, ns_red, ew_red}, 3'b011);
        chk("ack_total", acks - a0, 1);
        repeat (2) step();
        chk("ns_g_after_walk", ns_green, 1);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (ped_walk || !ns_green) bad++;
        end
        chk("no_second_walk", bad, 0);

        ew_car = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (ew_green) found = 1;
        end
        chk("wait_ew_g", found, 1);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        chk("ack_in_ew_g", ped_ack, 1);
        step();
        #1 rst_an = 1'b0;
        ew_car = 1'b0;
        #1;
        chk("rst_async", {ns_red, ns_green, ew_red, ew_green, ped_walk},
            5'b10100);
        @(negedge clk);
        rst_an = 1'b1;
        step();
        chk("rst_red0", {ns_red, ew_red}, 2'b11);
        step();
        chk("rst_ns_g", ns_green, 1);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (ped_walk || !ns_green) bad++;
        end
        chk("req_dropped", bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/junction_sequencer.md
# junction_sequencer

Timed phase sequencer for a two-road junction with a pedestrian crossing. It drives two three-lamp heads, north-south (NS) and east-west (EW), through green, yellow and all-red clearance phases. It serves an EW vehicle sensor and a latched pedestrian request. It sits above the single-head light FSMs and is the only source of lamp commands at the junction.

## Interface
Parameters:
- GREEN_CYC, 8: minimum NS green length and exact EW green length, in cycles.
- YELLOW_CYC, 3: yellow length, in cycles.
- ALLRED_CYC, 2: all-red clearance length, in cycles.
- PED_CYC, 5: pedestrian walk length, in cycles.
- All parameters must be in the range 1..256.

Ports:
- clk, input, 1: clock.
- rst_an, input, 1: asynchronous, active-low reset.
- ew_car, input, 1: EW vehicle present. Level, synchronous to clk.
- ped_req, input, 1: pedestrian button. Sampled every clk.
- ped_ack, output, 1: one-cycle pulse when a request is latched.
- ped_walk, output, 1: walk signal.
- ns_red, ns_yellow, ns_green, output, 1 each: NS lamps.
- ew_red, ew_yellow, ew_green, output, 1 each: EW lamps.

## Operation
- States: RED_NS, NS_G, NS_Y, RED_EW, EW_G, EW_Y, WALK.
- Lamp outputs are a Moore decode of the state register. Exactly one lamp per head is on at any time.
  - NS_G: ns_green=1, ew_red=1.
  - NS_Y: ns_yellow=1, ew_red=1.
  - EW_G: ew_green=1, ns_red=1.
  - EW_Y: ew_yellow=1, ns_red=1.
  - RED_NS, RED_EW, WALK: both heads red.
  - ped_walk=1 only in WALK.
- Down-counter timer, 8 bits. Loaded with (phase length − 1) on each state entry. Decrements each cycle, saturating at 0.
- Transitions (all evaluated when the timer is 0):
  - RED_NS → NS_G.
  - NS_G → NS_Y, but only if ew_car=1 or ped_pending=1. Otherwise NS_G holds indefinitely, with the timer held at 0.
  - NS_Y → RED_EW.
  - RED_EW → WALK if ped_pending=1, else EW_G.
  - WALK → EW_G if ew_car=1, else RED_NS.
  - EW_G → EW_Y.
  - EW_Y → RED_NS.
- ped_pending register:
  - Set on any cycle where ped_req=1 and ped_pending=0, except the cycle in which the FSM transitions into WALK and any cycle spent in WALK. Requests in those cycles are absorbed by the current walk.
  - Cleared on the transition into WALK.
  - ped_ack=1 on the cycle after ped_pending sets (registered).
  - Further ped_req while pending gives no ack and has no effect.
- Illegal or unused state encodings go to RED_NS on the next edge.

## Timing
- Reset (rst_an=0) acts immediately and asynchronously:
  - state=RED_NS, timer=ALLRED_CYC−1, ped_pending=0.
  - Outputs: ns_red=1, ew_red=1; all other lamps 0; ped_walk=0; ped_ack=0.
- Reset asserted mid-phase aborts the phase and drops any pending request.
- Cycle 0 is the first clk rise with rst_an=1.
  - RED_NS occupies cycles 0..ALLRED_CYC−1.
  - ns_green rises at the edge ending cycle ALLRED_CYC−1.
- Phase lengths (each excludes the other phases):
  - RED_NS, NS_Y, RED_EW, EW_G, EW_Y, WALK last exactly their parameter length.
  - NS_G lasts at least GREEN_CYC cycles.
- Demand arriving after the NS_G minimum has elapsed: NS_Y is entered at the next edge.
- ew_car is sampled only at the NS_G exit decision and the WALK exit decision. A deassertion later does not shorten EW_G.
- Full cycle with ew_car=1 held and no pedestrian: 2·(GREEN_CYC+YELLOW_CYC+ALLRED_CYC) cycles, 26 with defaults.

## Test plan
- Reset release:
  - ns_red=ew_red=1 for cycles 0–1, ns_green=1 from cycle 2.
  - Assert rst_an=0 mid-cycle (off a clk edge): outputs return to both-red immediately, without waiting for an edge.
- Idle hold: ew_car=0, ped_req=0 for 100 cycles → ns_green stays 1, ped_walk=0, ped_ack never pulses.
- Continuous traffic: ew_car=1 → repeating run of NS_G 8, NS_Y 3, RED_EW 2, EW_G 8, EW_Y 3, RED_NS 2 cycles, period 26. Exactly one lamp per head on at all times.
- Pedestrian request: ped_req pulse at NS_G cycle 3, ew_car=0 →
  - ped_ack at NS_G cycle 4.
  - Then NS_G ends after 8 cycles, NS_Y 3, RED_EW 2, WALK 5 with ped_walk=1, RED_NS 2, NS_G.
- Request collisions:
  - Second ped_req while pending → no second ack.
  - ped_req on the WALK-entry cycle and during WALK → absorbed, no ack, no second walk.
- Mid-operation reset: rst_an=0 during EW_G with a request pending → both heads red immediately. After release: RED_NS 2 cycles, then NS_G holds with no walk (the request was dropped).
